// File: rtl/cronometro_pkg.sv
// rtl/cronometro_pkg.sv - shared command, state and BCD limit constants for the stopwatch
package cronometro_pkg;

    // Command levels from the button decoder
    localparam logic [1:0] PARA  = 2'd0;
    localparam logic [1:0] PAUSE = 2'd1;
    localparam logic [1:0] RESET = 2'd2;
    localparam logic [1:0] CONTA = 2'd3;

    // Controller states
    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] STOP  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;

    // BCD digit limits
    localparam logic [3:0] BCD_MAX9 = 4'd9;
    localparam logic [3:0] BCD_MAX5 = 4'd5;

endpackage

// File: rtl/cronometro_if.sv
// rtl/cronometro_if.sv - command input and display/status bundle of the stopwatch controller
interface cronometro_if;

    logic [1:0] estado;
    logic [7:0] disp_mm;
    logic [7:0] disp_ss;
    logic [7:0] disp_cs;
    logic       running;
    logic       lap_active;
    logic       wrap;
    logic [1:0] fsm_state;

    // Button decoder / bench side
    modport master (
        output estado,
        input  disp_mm, disp_ss, disp_cs, running, lap_active, wrap, fsm_state
    );

    // Controller side
    modport slave (
        input  estado,
        output disp_mm, disp_ss, disp_cs, running, lap_active, wrap, fsm_state
    );

endinterface

// File: rtl/cronometro_bcd_mod.sv
// rtl/cronometro_bcd_mod.sv - two-digit BCD counter with synchronous clear and rollover carry
module cronometro_bcd_mod
    import cronometro_pkg::*;
#(
    parameter logic [3:0] TENS_MAX = BCD_MAX9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_q;
    logic [7:0] value_d;
    logic       units_max;
    logic       tens_max;

    assign units_max = (value_q[3:0] == BCD_MAX9);
    assign tens_max  = (value_q[7:4] == TENS_MAX);
    assign carry     = inc && units_max && tens_max;
    assign value     = value_q;

    // Next value: clear wins, otherwise units step and carry into tens, both roll at their limit
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 8'h00;
        end else if (inc) begin
            if (!units_max) begin
                value_d[3:0] = value_q[3:0] + 4'd1;
            end else begin
                value_d[3:0] = 4'd0;
                value_d[7:4] = tens_max ? 4'd0 : value_q[7:4] + 4'd1;
            end
        end
    end

    // Digit register, rewritten every cycle from the next-value logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// rtl/cronometro_ctrl.sv - stopwatch timebase: prescaler, run/stop/lap FSM, BCD time and lap snapshot
module cronometro_ctrl #(
    parameter int DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    cronometro_if.slave bus
);
    import cronometro_pkg::*;

    localparam int PW = $clog2(DIV);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [PW-1:0] presc_q;
    logic [23:0]   snap_q;
    logic [23:0]   live;
    logic [23:0]   shown;
    logic          advancing;
    logic          tick;
    logic          cmd_reset;
    logic          cnt_inc;
    logic          cs_carry;
    logic          ss_carry;
    logic          mm_carry;
    logic          wrap_q;
    logic [7:0]    cs_val;
    logic [7:0]    ss_val;
    logic [7:0]    mm_val;

    assign cmd_reset = (bus.estado == RESET);
    assign advancing = (state_q == RUN) || (state_q == LAP);
    assign tick      = advancing && (presc_q == PW'(DIV - 1));
    // A reset command on a tick edge must not advance the counters
    assign cnt_inc   = tick && !cmd_reset;
    assign live      = {mm_val, ss_val, cs_val};

    // Next state from the command level; reset and conta act from any state
    always_comb begin
        state_d = state_q;
        case (bus.estado)
            RESET:   state_d = CLEAR;
            CONTA:   state_d = RUN;
            PARA:    state_d = STOP;
            PAUSE:   if (state_q == RUN) state_d = LAP;
            default: state_d = state_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Prescaler: runs in RUN/LAP, holds in STOP so a resume finishes the partial period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (cmd_reset || tick) begin
            presc_q <= '0;
        end else if (advancing) begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Lap snapshot: takes the pre-edge live time when RUN sees pause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= 24'h000000;
        end else if (cmd_reset) begin
            snap_q <= 24'h000000;
        end else if ((state_q == RUN) && (bus.estado == PAUSE)) begin
            snap_q <= live;
        end
    end

    // Wrap pulse: the cycle after minutes roll 59 to 00
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= mm_carry;
        end
    end

    cronometro_bcd_mod #(.TENS_MAX(BCD_MAX9)) u_cs (
        .clk   (clk),
        .rst   (rst),
        .clr   (cmd_reset),
        .inc   (cnt_inc),
        .value (cs_val),
        .carry (cs_carry)
    );

    cronometro_bcd_mod #(.TENS_MAX(BCD_MAX5)) u_ss (
        .clk   (clk),
        .rst   (rst),
        .clr   (cmd_reset),
        .inc   (cs_carry),
        .value (ss_val),
        .carry (ss_carry)
    );

    cronometro_bcd_mod #(.TENS_MAX(BCD_MAX5)) u_mm (
        .clk   (clk),
        .rst   (rst),
        .clr   (cmd_reset),
        .inc   (ss_carry),
        .value (mm_val),
        .carry (mm_carry)
    );

    // Display mux: frozen snapshot in LAP, live time otherwise
    always_comb begin
        shown = live;
        if (state_q == LAP) begin
            shown = snap_q;
        end
    end

    assign bus.disp_mm    = shown[23:16];
    assign bus.disp_ss    = shown[15:8];
    assign bus.disp_cs    = shown[7:0];
    assign bus.running    = advancing;
    assign bus.lap_active = (state_q == LAP);
    assign bus.wrap       = wrap_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// tb/tb_cronometro_ctrl.sv - scoreboard bench for cronometro_ctrl with a centisecond reference model
module tb_cronometro_ctrl;
    import cronometro_pkg::*;

    localparam int DIV      = 4;
    localparam int DAY_CS   = 360000;

    typedef struct {
        string       tag;
        logic [31:0] vec;
    } sb_entry_t;

    logic clk;
    logic rst;

    cronometro_if bus ();

    cronometro_ctrl #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int        n_checks = 0;
    int        n_pass   = 0;
    sb_entry_t sb_q[$];
    sb_entry_t mon_e;

    int m_state;
    int m_presc;
    int m_time;
    int m_snap;
    bit m_wrap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] to_bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_presc = 0;
        m_time  = 0;
        m_snap  = 0;
        m_wrap  = 1'b0;
    endfunction

    // One clock edge of the reference behaviour for command cmd
    function automatic void model_step(input logic [1:0] cmd);
        bit adv;
        bit tk;
        adv = (m_state == 2) || (m_state == 3);
        tk  = adv && (m_presc == DIV - 1);
        if (cmd == RESET) begin
            model_reset();
            return;
        end
        m_wrap = tk && (m_time == DAY_CS - 1);
        if ((m_state == 2) && (cmd == PAUSE)) m_snap = m_time;
        if (tk) m_time = (m_time + 1) % DAY_CS;
        if (adv) m_presc = tk ? 0 : m_presc + 1;
        case (cmd)
            CONTA: m_state = 2;
            PARA:  m_state = 1;
            PAUSE: if (m_state == 2) m_state = 3;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_vec();
        int t;
        t = (m_state == 3) ? m_snap : m_time;
        return {3'b000, to_bcd(t / 6000), to_bcd((t / 100) % 60), to_bcd(t % 100),
                1'(m_state >= 2), 1'(m_state == 3), m_wrap, 2'(m_state)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {3'b000, bus.disp_mm, bus.disp_ss, bus.disp_cs,
                bus.running, bus.lap_active, bus.wrap, bus.fsm_state};
    endfunction

    task automatic drive(input logic [1:0] cmd, input string tag);
        sb_entry_t e;
        @(negedge clk);
        bus.estado = cmd;
        model_step(cmd);
        e.tag = tag;
        e.vec = model_vec();
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a pending expectation is compared just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check(mon_e.tag, dut_vec(), mon_e.vec);
            end
        end
    end

    initial begin
        int n;
        int n_wrap;

        // 1: power-on reset, then an async reset pulse mid-cycle while counting
        rst        = 1'b1;
        bus.estado = PARA;
        model_reset();
        #2;
        check("reset_state", dut_vec(), 32'h0);
        #10;
        rst = 1'b0;
        repeat (20) drive(CONTA, "t1_run");
        @(posedge clk);
        #2;
        bus.estado = PARA;
        #1;
        rst = 1'b1;
        #1;
        check("t1_async_rst", dut_vec(), 32'h0);
        model_reset();
        rst = 1'b0;

        // 2: one second of counting from CLEAR
        repeat (401) drive(CONTA, "t2_run");
        settle();
        check("t2_one_second", {8'h0, bus.disp_mm, bus.disp_ss, bus.disp_cs}, 32'h00000100);
        check("t2_running", 32'(bus.running), 32'd1);

        // 3: lap at 12.34, display frozen while live continues, then back to live
        for (int i = 0; i < 8000 && m_time != 1234; i++) drive(CONTA, "t3_run");
        if (m_time != 1234) check("t3_reach_timeout", 32'(m_time), 32'd1234);
        repeat (41) drive(PAUSE, "t3_lap");
        settle();
        check("t3_frozen", {8'h0, bus.disp_mm, bus.disp_ss, bus.disp_cs}, 32'h00001234);
        check("t3_lap_state", 32'(bus.fsm_state), 32'(LAP));
        drive(CONTA, "t3_resume");
        settle();
        check("t3_lap_off", 32'(bus.lap_active), 32'd0);

        // 4: stop mid-period; resume finishes the partial prescaler period
        drive(RESET, "t4_clear");
        for (int i = 0; i < 100 && m_time != 5; i++) drive(CONTA, "t4_run");
        if (m_time != 5) check("t4_reach_timeout", 32'(m_time), 32'd5);
        repeat (2) drive(CONTA, "t4_partial");
        repeat (100) drive(PARA, "t4_stop");
        settle();
        check("t4_held_time", {8'h0, bus.disp_mm, bus.disp_ss, bus.disp_cs}, 32'h00000005);
        check("t4_held_presc", 32'(dut.presc_q), 32'd3);
        n = 0;
        do begin
            drive(CONTA, "t4_resume");
            settle();
            n++;
        end while (bus.disp_cs != 8'h06 && n < 10);
        check("t4_resume_latency", 32'(n), 32'd2);

        // 5: preload 59:59.99 while stopped, then roll over
        repeat (2) drive(PARA, "t5_stop");
        @(negedge clk);
        force dut.u_cs.value_q = 8'h99;
        force dut.u_ss.value_q = 8'h59;
        force dut.u_mm.value_q = 8'h59;
        bus.estado = PARA;
        model_step(PARA);
        m_time = DAY_CS - 1;
        sb_q.push_back('{"t5_preload", model_vec()});
        @(posedge clk);
        #2;
        release dut.u_cs.value_q;
        release dut.u_ss.value_q;
        release dut.u_mm.value_q;
        n_wrap = 0;
        for (int i = 0; i < 16; i++) begin
            drive(CONTA, "t5_wrap_run");
            settle();
            if (bus.wrap) n_wrap++;
        end
        check("t5_wrap_once", 32'(n_wrap), 32'd1);
        check("t5_rolled", {16'h0, bus.disp_mm, bus.disp_ss}, 32'h0);

        // 6: reset command on the same edge as a tick at 00:07.42, then pause in CLEAR
        drive(RESET, "t6_clear");
        for (int i = 0; i < 5000 && !(m_time == 742 && m_presc == DIV - 1); i++) drive(CONTA, "t6_run");
        if (m_time != 742) check("t6_reach_timeout", 32'(m_time), 32'd742);
        drive(RESET, "t6_reset_tick");
        settle();
        check("t6_disp_zero", {8'h0, bus.disp_mm, bus.disp_ss, bus.disp_cs}, 32'h0);
        check("t6_state_clear", 32'(bus.fsm_state), 32'(CLEAR));
        check("t6_presc_zero", 32'(dut.presc_q), 32'd0);
        repeat (3) drive(PAUSE, "t6_pause_clear");
        settle();
        check("t6_pause_ignored", 32'(bus.fsm_state), 32'(CLEAR));

        n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb_q.size() > 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cronometro_ctrl.md
Name: cronometro_ctrl

Overview:
- Controls and holds the stopwatch timebase: mm:ss.cc counters in BCD plus the display-hold (lap) register.
- Runs from the 2-bit command level produced by the button decoder: para=0, pause=1, reset=2, conta=3. The command holds its value until the next button release.
- Sits between the button decoder and the 7-segment display drivers.
- Owns the prescaler, the run/stop/lap FSM, and the frozen-display snapshot.

Parameters:
- DIV, 500000, clk cycles per 1/100 s tick (50 MHz to 100 Hz). Minimum 2. Prescaler width is clog2(DIV).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- estado  input  2  command level from the button decoder (0 para, 1 pause, 2 reset, 3 conta).
- disp_mm  output  8  minutes, two BCD digits {tens,units}, 00-59.
- disp_ss  output  8  seconds, two BCD digits, 00-59.
- disp_cs  output  8  centiseconds, two BCD digits, 00-99.
- running  output  1  high in RUN or LAP (time advancing).
- lap_active  output  1  high in LAP (display frozen).
- wrap  output  1  one-cycle pulse when time rolls 59:59.99 to 00:00.00.
- fsm_state  output  2  current FSM state encoding, for debug.

Behaviour:
- Reset (rst=1, async): state=CLEAR; prescaler, live counters and snapshot all 0. Outputs: disp_* 8'h00, running=0, lap_active=0, wrap=0.
- States: CLEAR=0, STOP=1, RUN=2, LAP=3. The command is sampled every posedge and acts as a level.
- Transitions, evaluated on current state and estado:
  - estado=reset: from any state to CLEAR. Highest priority; it wins over a coincident tick.
  - estado=conta: from any state to RUN. In LAP, the display returns to live from the next cycle.
  - estado=para: from RUN, LAP or CLEAR to STOP; STOP holds.
  - estado=pause: RUN to LAP, capturing the snapshot. LAP holds. STOP and CLEAR ignore pause and hold.
- Prescaler:
  - Counts 0..DIV-1 only while state is RUN or LAP.
  - tick is asserted combinationally when prescaler==DIV-1 and state is RUN/LAP. The prescaler then wraps to 0.
  - Holds its value in STOP, so a resume continues the partial period.
  - Cleared on any edge where estado=reset.
- Live counters (cs mod 100, ss mod 60, mm mod 60, all BCD):
  - Increment on edges where tick=1 and estado!=reset. The command's state change takes effect from the next cycle.
  - Carry chain:
    - cs units 9 to 0 carries into cs tens.
    - cs 99 to 00 carries into ss.
    - ss 59 to 00 carries into mm.
    - mm 59 to 00 asserts wrap on the following cycle, for exactly one cycle.
  - No invalid BCD value (nibble > 9, tens > 5 for ss/mm) is ever reachable.
- Snapshot:
  - On the edge where state=RUN and estado=pause, the snapshot loads the live counter value registered before that edge.
  - The snapshot does not include a coincident tick increment.
- Display mux: disp_* = snapshot when state=LAP, otherwise live counters. The mux is combinational from registers; no extra latency.
- Reset mid-count: the next edge zeroes everything and the display shows 00:00.00 one cycle after the command arrives.
- Simultaneous tick and state change: the counter update uses the current state; the new state applies next cycle.
- running = state is RUN or LAP; lap_active = state is LAP. Both are decoded from the state register.

Decomposition:
- Package cronometro_pkg holds:
  - command constants PARA=0, PAUSE=1, RESET=2, CONTA=3;
  - state encodings CLEAR/STOP/RUN/LAP;
  - BCD limit constants 9, 5.
- Sub-module cronometro_bcd_mod: a two-digit BCD counter.
  - Parameter TENS_MAX: 9 for cs, 5 for ss/mm.
  - Inputs: clk, rst, clr, inc.
  - Outputs: value[7:0], carry (combinational, equals inc at max).
  - Instantiated three times with the carry chained into the next counter's inc.

Test Plan (DIV=4):
1. rst pulse mid-cycle, estado=para -> all outputs 0 immediately (async); state=CLEAR; disp 00:00.00.
2. estado=conta for 400 clk -> disp_cs=8'h00, disp_ss=8'h01, disp_mm=8'h00; running=1; tick every 4th clk.
3. Count to 12.34, estado=pause, then 40 more clk -> display stays 00:12.34, live reaches 12.44. Then estado=conta -> display shows 12.44 next cycle.
4. Count to 00:00.05 plus 2 prescaler cycles, estado=para for 100 clk, then conta -> time unchanged while stopped; the first tick after resume comes 2 clk later.
5. Preload via count to 59:59.99 (long run), one more tick -> disp 00:00.00; wrap high exactly one cycle.
6. estado=reset asserted on the same edge as a tick at 00:07.42 -> next cycle disp 00:00.00, state=CLEAR, prescaler 0; pause in CLEAR -> stays CLEAR.
